// File: rtl/code_entry_pkg.sv
// Shared types and width helpers for the code entry buffer and its button arbiter.
package code_entry_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } arb_state_t;

  // ceil(log2(n)), never below 1 so a field always has at least one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << (i - 1)) < n) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/code_entry_buf_btn_arbiter.sv
// Button arbiter: accepts a single isolated press once, then locks out until every request is released.
module btn_arbiter
  import code_entry_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic               accept,
  output logic [IDX_W-1:0]   idx
);

  arb_state_t state, state_next;
  logic       any_req;
  logic       multi_req;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  always_comb begin
    any_req   = |req;
    multi_req = |(req & (req - NUM_REQ'(1)));
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) idx = idx | IDX_W'(i);
    end
  end

  // NOTE: state registers use non-blocking assignments only; comb blocks use blocking.
  always_ff @(posedge clk) begin
    if (reset) state <= HELD;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      ARMED: begin
        if (any_req) begin
          accept     = !multi_req;
          state_next = HELD;
        end
      end
      HELD: begin
        if (!any_req) state_next = ARMED;
      end
      default: state_next = HELD;
    endcase
  end

endmodule

// File: rtl/code_entry_buf.sv
// Code entry buffer: guess and key digit buffers fed by an arbitrated button set, with match detection.
// Optional backspace button: define CODE_ENTRY_BKSP_EN.
module code_entry_buf
  import code_entry_pkg::*;
#(
  parameter  int NUM_SYM  = 4,
  parameter  int CODE_LEN = 4,
  localparam int SYM_W    = clog2_min1(NUM_SYM),
  localparam int CODE_W   = CODE_LEN * SYM_W,
  localparam int CNT_W    = clog2_min1(CODE_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SYM-1:0] btn,
  input  logic               edit,
  input  logic               clr,
`ifdef CODE_ENTRY_BKSP_EN
  input  logic               bksp,
`endif
  output logic [CODE_W-1:0]  guess,
  output logic [CODE_W-1:0]  key,
  output logic [CNT_W-1:0]   cnt,
  output logic               pressed,
  output logic               guess_done,
  output logic               key_done,
  output logic               match
);

`ifdef CODE_ENTRY_BKSP_EN
  localparam int NUM_REQ = NUM_SYM + 1;
`else
  localparam int NUM_REQ = NUM_SYM;
`endif
  localparam int               IDX_W    = clog2_min1(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [NUM_REQ-1:0] req;
  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic               is_bksp;
  logic [SYM_W-1:0]   sym;

  logic               edit_q;
  logic [CNT_W-1:0]   guess_cnt;
  logic [CNT_W-1:0]   key_cnt;

  logic [CODE_W-1:0]  act_buf;
  logic [CODE_W-1:0]  act_buf_next;
  logic [CNT_W-1:0]   act_cnt;
  logic [CNT_W-1:0]   act_cnt_next;
  logic               wr_sym;
  logic               fill;

  // Backspace rides on the arbiter as the request just above the symbol buttons.
`ifdef CODE_ENTRY_BKSP_EN
  assign req     = {bksp, btn};
  assign is_bksp = (idx == IDX_W'(NUM_SYM));
`else
  assign req     = btn;
  assign is_bksp = 1'b0;
`endif
  assign sym = SYM_W'(idx);

  btn_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .accept(accept),
    .idx   (idx)
  );

  assign act_buf = edit_q ? key : guess;
  assign act_cnt = edit_q ? key_cnt : guess_cnt;
  assign cnt     = act_cnt;

  // clr outranks any accept; a full buffer ignores symbols but still takes backspace.
  always_comb begin
    act_buf_next = act_buf;
    act_cnt_next = act_cnt;
    wr_sym       = 1'b0;
    fill         = 1'b0;
    if (clr) begin
      act_buf_next = '0;
      act_cnt_next = '0;
    end else if (accept && is_bksp) begin
      if (act_cnt != '0) begin
        act_cnt_next = act_cnt - ONE_CNT;
        for (int k = 0; k < CODE_LEN; k++) begin
          if (CNT_W'(k) == act_cnt_next) act_buf_next[k*SYM_W +: SYM_W] = '0;
        end
      end
    end else if (accept && (act_cnt != FULL_CNT)) begin
      wr_sym       = 1'b1;
      act_cnt_next = act_cnt + ONE_CNT;
      fill         = (act_cnt_next == FULL_CNT);
      for (int k = 0; k < CODE_LEN; k++) begin
        if (CNT_W'(k) == act_cnt) act_buf_next[k*SYM_W +: SYM_W] = sym;
      end
    end
  end

  // NOTE: the digit buffers are plain flops, not RAM, so reset clears them directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      edit_q     <= 1'b0;
      guess      <= '0;
      key        <= '0;
      guess_cnt  <= '0;
      key_cnt    <= '0;
      pressed    <= 1'b0;
      guess_done <= 1'b0;
      key_done   <= 1'b0;
      match      <= 1'b0;
    end else begin
      edit_q     <= edit;
      pressed    <= wr_sym;
      guess_done <= fill && !edit_q;
      key_done   <= fill && edit_q;
      match      <= (guess_cnt == FULL_CNT) && (key_cnt == FULL_CNT) && (guess == key);
      if (edit_q) begin
        key     <= act_buf_next;
        key_cnt <= act_cnt_next;
      end else begin
        guess     <= act_buf_next;
        guess_cnt <= act_cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_code_entry_buf.sv
// Self-checking bench for code_entry_buf: directed scenarios plus randomized traffic against a digit-array model.
module tb_code_entry_buf;

  localparam int NUM_SYM  = 4;
  localparam int CODE_LEN = 4;
  localparam int SYM_W    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       edit;
  logic       clr;
`ifdef CODE_ENTRY_BKSP_EN
  logic       bksp_in;
`endif
  logic [7:0] guess;
  logic [7:0] key;
  logic [2:0] cnt;
  logic       pressed;
  logic       guess_done;
  logic       key_done;
  logic       match;

  int errors = 0;
  int checks = 0;
  int n_pressed = 0;
  int n_gdone = 0;
  int n_kdone = 0;

  // Reference model: per-buffer digit arrays with a fill count, plus a "waiting for release" flag.
  int m_dig[2][CODE_LEN];
  int m_n[2];
  bit m_held, m_edit_q, m_match, m_pressed, m_gdone, m_kdone;

  always #5 clk = ~clk;

  code_entry_buf #(
    .NUM_SYM (NUM_SYM),
    .CODE_LEN(CODE_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .edit      (edit),
    .clr       (clr),
`ifdef CODE_ENTRY_BKSP_EN
    .bksp      (bksp_in),
`endif
    .guess     (guess),
    .key       (key),
    .cnt       (cnt),
    .pressed   (pressed),
    .guess_done(guess_done),
    .key_done  (key_done),
    .match     (match)
  );

  function automatic logic [7:0] m_pack(input int a);
    int v;
    v = 0;
    for (int k = 0; k < CODE_LEN; k++) v = v + m_dig[a][k] * (1 << (k * SYM_W));
    return 8'(v);
  endfunction

  function automatic int sym_of(input logic [3:0] b);
    int s;
    s = 0;
    for (int i = 0; i < NUM_SYM; i++) if (b[i]) s = i;
    return s;
  endfunction

  task automatic model_step(input logic [3:0] b, input bit e, input bit c, input bit bk, input bit r);
    int  ones;
    int  a;
    bit  acc;
    bit  nm;
    if (r) begin
      for (int x = 0; x < 2; x++) begin
        m_n[x] = 0;
        for (int k = 0; k < CODE_LEN; k++) m_dig[x][k] = 0;
      end
      m_held = 1; m_edit_q = 0; m_match = 0; m_pressed = 0; m_gdone = 0; m_kdone = 0;
      return;
    end
    nm     = (m_n[0] == CODE_LEN) && (m_n[1] == CODE_LEN) && (m_pack(0) == m_pack(1));
    ones   = $countones(b) + int'(bk);
    acc    = !m_held && (ones == 1);
    m_held = (ones != 0);
    a      = int'(m_edit_q);
    m_pressed = 0; m_gdone = 0; m_kdone = 0;
    if (c) begin
      m_n[a] = 0;
      for (int k = 0; k < CODE_LEN; k++) m_dig[a][k] = 0;
    end else if (acc && bk) begin
      if (m_n[a] > 0) begin
        m_n[a] = m_n[a] - 1;
        m_dig[a][m_n[a]] = 0;
      end
    end else if (acc && m_n[a] < CODE_LEN) begin
      m_dig[a][m_n[a]] = sym_of(b);
      m_n[a] = m_n[a] + 1;
      m_pressed = 1;
      if (m_n[a] == CODE_LEN) begin
        if (a == 1) m_kdone = 1;
        else        m_gdone = 1;
      end
    end
    m_edit_q = e;
    m_match  = nm;
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic [3:0] b, input bit e, input bit c, input bit bk, input bit r);
    btn = b; edit = e; clr = c; reset = r;
`ifdef CODE_ENTRY_BKSP_EN
    bksp_in = bk;
`endif
    model_step(b, e, c, bk, r);
    @(posedge clk);
    #1;
    if (pressed)    n_pressed++;
    if (guess_done) n_gdone++;
    if (key_done)   n_kdone++;
  endtask

  task automatic press(input int s, input bit e);
    drive(4'(1 << s), e, 0, 0, 0);
    drive(4'b0000, e, 0, 0, 0);
  endtask

  task automatic test_reset;
    drive(4'b0000, 0, 0, 0, 1);
    drive(4'b0000, 0, 0, 0, 1);
    checks++; if (guess !== 8'h00) begin errors++; $display("FAIL reset_guess: got %h want 00", guess); end
    checks++; if (key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h want 00", key); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    checks++; if ({pressed, guess_done, key_done, match} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {pressed, guess_done, key_done, match});
    end
    drive(4'b0000, 0, 0, 0, 0);
  endtask

  task automatic test_guess_entry;
    n_pressed = 0; n_gdone = 0;
    press(2, 0); press(0, 0); press(3, 0); press(1, 0);
    drive(4'b0000, 0, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (guess !== 8'b01_11_00_10) begin errors++; $display("FAIL entry_guess: got %b want 01110010", guess); end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL entry_cnt: got %0d want 4", cnt); end
    checks++; if (n_gdone != 1) begin errors++; $display("FAIL entry_done_pulses: got %0d want 1", n_gdone); end
    checks++; if (n_pressed != 4) begin errors++; $display("FAIL entry_pressed_pulses: got %0d want 4", n_pressed); end
  endtask

  task automatic test_multi_press;
    drive(4'b0000, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    n_pressed = 0;
    drive(4'b0011, 0, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (n_pressed != 0) begin errors++; $display("FAIL multi_pressed: got %0d want 0", n_pressed); end
    checks++; if (cnt !== 3'd0 || guess !== 8'h00) begin
      errors++; $display("FAIL multi_nowrite: got cnt=%0d guess=%h want 0/00", cnt, guess);
    end
    press(3, 0);
    checks++; if (cnt !== 3'd1 || guess !== 8'h03) begin
      errors++; $display("FAIL multi_next_accept: got cnt=%0d guess=%h want 1/03", cnt, guess);
    end
  endtask

  task automatic test_hold;
    n_pressed = 0;
    repeat (10) drive(4'b0010, 0, 0, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (n_pressed != 1) begin errors++; $display("FAIL hold_pressed: got %0d want 1", n_pressed); end
    checks++; if (cnt !== 3'd2 || guess !== 8'h07) begin
      errors++; $display("FAIL hold_write: got cnt=%0d guess=%h want 2/07", cnt, guess);
    end
  endtask

  task automatic test_match;
    drive(4'b0000, 0, 1, 0, 0);
    drive(4'b0000, 1, 0, 0, 0);
    drive(4'b0000, 1, 1, 0, 0);
    n_kdone = 0; n_gdone = 0;
    press(2, 1); press(0, 1); press(3, 1); press(1, 1);
    checks++; if (key !== 8'h72) begin errors++; $display("FAIL match_key: got %h want 72", key); end
    checks++; if (n_kdone != 1 || n_gdone != 0) begin
      errors++; $display("FAIL match_key_done: got key=%0d guess=%0d want 1/0", n_kdone, n_gdone);
    end
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (cnt !== 3'd0 || key !== 8'h72) begin
      errors++; $display("FAIL match_mode_switch: got cnt=%0d key=%h want 0/72", cnt, key);
    end
    press(2, 0); press(0, 0); press(3, 0); press(1, 0);
    checks++; if (match !== 1'b1 || guess !== 8'h72) begin
      errors++; $display("FAIL match_high: got match=%b guess=%h want 1/72", match, guess);
    end
    drive(4'b0000, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (guess !== 8'h00 || match !== 1'b0 || cnt !== 3'd0) begin
      errors++; $display("FAIL match_clr: got guess=%h match=%b cnt=%0d want 00/0/0", guess, match, cnt);
    end
    checks++; if (key !== 8'h72) begin errors++; $display("FAIL match_key_kept: got %h want 72", key); end
  endtask

`ifdef CODE_ENTRY_BKSP_EN
  task automatic test_bksp;
    drive(4'b0000, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    press(1, 0); press(2, 0); press(3, 0);
    n_pressed = 0;
    drive(4'b0000, 0, 0, 1, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (cnt !== 3'd2 || guess !== 8'h09) begin
      errors++; $display("FAIL bksp_erase: got cnt=%0d guess=%h want 2/09", cnt, guess);
    end
    checks++; if (n_pressed != 0) begin errors++; $display("FAIL bksp_pressed: got %0d want 0", n_pressed); end
    drive(4'b0001, 0, 0, 1, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (cnt !== 3'd2) begin errors++; $display("FAIL bksp_multi: got cnt=%0d want 2", cnt); end
    n_gdone = 0;
    press(3, 0); press(1, 0);
    n_pressed = 0;
    press(1, 0);
    checks++; if (cnt !== 3'd4 || guess !== 8'h79 || n_pressed != 0) begin
      errors++; $display("FAIL bksp_full_lock: got cnt=%0d guess=%h pressed=%0d want 4/79/0", cnt, guess, n_pressed);
    end
    drive(4'b0000, 0, 0, 1, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (cnt !== 3'd3 || guess !== 8'h39) begin
      errors++; $display("FAIL bksp_unlock: got cnt=%0d guess=%h want 3/39", cnt, guess);
    end
    press(2, 0);
    checks++; if (guess !== 8'hB9 || n_gdone != 2) begin
      errors++; $display("FAIL bksp_refill: got guess=%h done=%0d want B9/2", guess, n_gdone);
    end
    drive(4'b0000, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 1, 0);
    drive(4'b0000, 0, 0, 0, 0);
    checks++; if (cnt !== 3'd0 || guess !== 8'h00) begin
      errors++; $display("FAIL bksp_empty: got cnt=%0d guess=%h want 0/00", cnt, guess);
    end
  endtask
`endif

  task automatic test_reset_mid_entry;
    drive(4'b0000, 0, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 0);
    press(1, 0); press(2, 0);
    drive(4'b0001, 0, 0, 0, 1);
    drive(4'b0001, 0, 0, 0, 1);
    checks++; if (guess !== 8'h00 || key !== 8'h00 || cnt !== 3'd0) begin
      errors++; $display("FAIL rst_mid_bufs: got guess=%h key=%h cnt=%0d want 00/00/0", guess, key, cnt);
    end
    checks++; if ({pressed, guess_done, key_done, match} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 0000", {pressed, guess_done, key_done, match});
    end
    n_pressed = 0;
    repeat (3) drive(4'b0001, 0, 0, 0, 0);
    checks++; if (n_pressed != 0 || cnt !== 3'd0) begin
      errors++; $display("FAIL rst_mid_lockout: got pressed=%0d cnt=%0d want 0/0", n_pressed, cnt);
    end
    drive(4'b0000, 0, 0, 0, 0);
    press(0, 0);
    checks++; if (n_pressed != 1 || cnt !== 3'd1) begin
      errors++; $display("FAIL rst_mid_after_release: got pressed=%0d cnt=%0d want 1/1", n_pressed, cnt);
    end
  endtask

  task automatic test_random;
    logic [3:0] b;
    bit         e, c, bk, r;
    int         pick;
    e = 0;
    drive(4'b0000, 0, 0, 0, 1);
    for (int cyc = 0; cyc < 800; cyc++) begin
      pick = int'($urandom_range(99));
      if (pick < 45)      b = 4'b0000;
      else if (pick < 85) b = 4'(1 << $urandom_range(3));
      else                b = 4'($urandom_range(15));
      if ($urandom_range(99) < 6) e = !e;
      c  = ($urandom_range(99) < 4);
`ifdef CODE_ENTRY_BKSP_EN
      bk = ($urandom_range(99) < 8);
`else
      bk = 0;
`endif
      r  = ($urandom_range(299) == 0);
      drive(b, e, c, bk, r);
      checks++; if (guess !== m_pack(0)) begin errors++; $display("FAIL rand_guess @%0d: got %h want %h", cyc, guess, m_pack(0)); end
      checks++; if (key !== m_pack(1)) begin errors++; $display("FAIL rand_key @%0d: got %h want %h", cyc, key, m_pack(1)); end
      checks++; if (cnt !== 3'(m_n[int'(m_edit_q)])) begin
        errors++; $display("FAIL rand_cnt @%0d: got %0d want %0d", cyc, cnt, m_n[int'(m_edit_q)]);
      end
      checks++; if (pressed !== m_pressed) begin errors++; $display("FAIL rand_pressed @%0d: got %b want %b", cyc, pressed, m_pressed); end
      checks++; if (guess_done !== m_gdone) begin errors++; $display("FAIL rand_guess_done @%0d: got %b want %b", cyc, guess_done, m_gdone); end
      checks++; if (key_done !== m_kdone) begin errors++; $display("FAIL rand_key_done @%0d: got %b want %b", cyc, key_done, m_kdone); end
      checks++; if (match !== m_match) begin errors++; $display("FAIL rand_match @%0d: got %b want %b", cyc, match, m_match); end
    end
  endtask

  initial begin
    btn = '0; edit = 1'b0; clr = 1'b0; reset = 1'b1;
`ifdef CODE_ENTRY_BKSP_EN
    bksp_in = 1'b0;
`endif
    test_reset();
    test_guess_entry();
    test_multi_press();
    test_hold();
    test_match();
`ifdef CODE_ENTRY_BKSP_EN
    test_bksp();
`endif
    test_reset_mid_entry();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
